sr_cmd_conditioner: RTL
=======================

Name: sr_cmd_conditioner

Overview:
Upstream command stage for the SR flip-flop. Synchronises and debounces two raw request lines (set, clear), detects their rising edges and arbitrates them. Emits single-cycle, mutually exclusive S/R pulses with an enforced minimum spacing. The S=R=1 invalid combination is therefore never presented downstream.

Parameters:
DB_CYCLES, 4, consecutive stable synced cycles required before a debounced level changes (>=1)
DB_W, 8, debounce counter width; must satisfy 2**DB_W > DB_CYCLES
GAP_CYCLES, 2, idle cycles forced after each issued pulse (0 allowed)
SET_PRIORITY, 1, 1 = set wins a simultaneous conflict, 0 = clear wins

Ports:
clk  input  1  clock; all logic on posedge
rst_n  input  1  reset; asynchronous, active-low
set_in  input  1  raw set request, asynchronous to clk
clr_in  input  1  raw clear request, asynchronous to clk
S  output  1  registered set pulse to flip-flop, one cycle wide
R  output  1  registered reset pulse to flip-flop, one cycle wide
busy  output  1  high in ISSUE and GAP states
conflict  output  1  one-cycle pulse when both requests were pending at arbitration
conflict_cnt  output  8  saturating conflict count (only with SR_CONFLICT_CNT_EN)

Behaviour:
- Reset (rst_n=0, async): all flops 0; S=R=busy=conflict=0; FSM=IDLE; pending flags, debounce state and counters cleared. Mid-operation reset aborts any pulse or gap immediately.
- Sync: each raw input passes through a 2-flop synchroniser, reset 0.
- Debounce, per channel: stable level reg (reset 0) plus counter.
  - synced==stable -> counter=0.
  - Otherwise counter increments. When counter==DB_CYCLES-1 and synced still differs, stable<=synced and counter<=0.
  - Glitch shorter than DB_CYCLES cycles -> no change.
- Edge: rise = stable & ~stable_d (stable_d is registered). Falling edges are ignored.
- Pending: rise sets set_pend/clr_pend next cycle. A flag clears when its channel is issued or dropped. A repeated rise on an already-pending channel is absorbed (no queueing beyond 1).
- FSM:
  - IDLE: if any pend -> ISSUE. Only set_pend -> S=1. Only clr_pend -> R=1. Both -> priority channel pulses, other flag dropped, conflict=1 for that cycle. Both flags clear on the transition.
  - ISSUE (1 cycle, pulse visible): GAP_CYCLES>0 -> GAP with gap counter=GAP_CYCLES-1; else -> IDLE.
  - GAP: counter decrements; ->IDLE when 0. Rises arriving in ISSUE/GAP set pend and are served after return to IDLE.
- Invariant: S&R never 1; each pulse exactly 1 cycle; consecutive pulses separated by >= GAP_CYCLES+1 low cycles.
- Latency: raw edge sampled at cycle 0 -> S/R high in cycle DB_CYCLES+4 when FSM is IDLE (8 cycles at default).
- Raw level held high indefinitely -> exactly one pulse.

Optional Feature:
SR_CONFLICT_CNT_EN
- Defined: conflict_cnt port present. 8-bit counter, reset 0, +1 on each conflict pulse, saturates at 255.
- Undefined: port and counter absent; conflict pulse unaffected.

Decomposition:
- Package sr_cmd_pkg: FSM state enum typedef (IDLE, ISSUE, GAP) and default constants for DB_CYCLES and GAP_CYCLES.
- Sub-module sr_debounce (synchroniser + debounce + rise detect, parameterised by DB_CYCLES/DB_W), instantiated once per channel.

Test Plan:
- Reset: hold rst_n=0 with set_in=1; release -> S=R=0 for 8 cycles, then one S pulse at cycle 8 after first sampling.
- Glitch: set_in high for 3 cycles (DB_CYCLES=4) -> no S pulse, pending stays 0.
- Clean set: set_in 0->1 held -> S=1 exactly one cycle at cycle 8; busy high 3 cycles (ISSUE+2 GAP); R stays 0.
- Simultaneous: set_in, clr_in rise same cycle, SET_PRIORITY=1 -> single S pulse, conflict=1 same cycle, no R; conflict_cnt=1 with macro.
- Back-to-back: clr rise lands in GAP after an S pulse -> R pulse exactly GAP_CYCLES+1 cycles after S falls, never overlapping.
- Async reset mid-GAP: drop rst_n during GAP -> busy=0 immediately, pending cleared, no pulse after release until a new debounced rise.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// Shared types and default constants for the S/R command conditioner.
package sr_cmd_pkg;

  // Arbiter/pulse generator states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DB_CYCLES_DEF  = 4;
  localparam int GAP_CYCLES_DEF = 2;

endpackage : sr_cmd_pkg

// File: rtl/sr_debounce.sv
// One request channel: 2-flop synchroniser, counter debounce and a
// registered rising-edge strobe of the debounced level.
module sr_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_rise
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [1:0]      r_sync;
  logic            r_stable;
  logic            r_stable_d;
  logic            r_rise;
  logic [DB_W-1:0] r_cnt;
  logic            w_synced;

  assign w_synced = r_sync[1];

  // Two-flop synchroniser for the asynchronous raw request.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], i_raw};
  end

  // Accept a new level only after it has been seen DB_CYCLES edges in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (w_synced == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == DB_LAST) begin
      r_stable <= w_synced;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered rising edge of the debounced level; falling edges are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable_d <= 1'b0;
      r_rise     <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      r_rise     <= r_stable & ~r_stable_d;
    end
  end

  assign o_rise = r_rise;

endmodule : sr_debounce

// File: rtl/sr_cmd_conditioner.sv
// Conditions raw set/clear requests into single-cycle, mutually exclusive
// S/R pulses with a forced idle gap after each one. Simultaneous requests
// are resolved by SET_PRIORITY and flagged on `conflict`.
// Optional: define SR_CONFLICT_CNT_EN to add the saturating conflict_cnt port.
module sr_cmd_conditioner
  import sr_cmd_pkg::*;
#(
  parameter int DB_CYCLES    = DB_CYCLES_DEF,
  parameter int DB_W         = 8,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter bit SET_PRIORITY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_in,
  input  logic       clr_in,
  output logic       S,
  output logic       R,
  output logic       busy,
  output logic       conflict
`ifdef SR_CONFLICT_CNT_EN
  ,
  output logic [7:0] conflict_cnt
`endif
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t           r_state, w_state_nxt;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_nxt;
  logic             r_s, r_r, r_conflict;
  logic             w_s_nxt, w_r_nxt, w_conf_nxt;
  logic             r_set_pend, r_clr_pend;
  logic             w_take;
  logic             w_set_rise, w_clr_rise;

  sr_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_set (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_raw  (set_in),
    .o_rise (w_set_rise)
  );

  sr_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_clr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_raw  (clr_in),
    .o_rise (w_clr_rise)
  );

  // One-deep pending flags: a rise sets, leaving IDLE clears both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set_pend <= 1'b0;
      r_clr_pend <= 1'b0;
    end else begin
      r_set_pend <= w_set_rise | (r_set_pend & ~w_take);
      r_clr_pend <= w_clr_rise | (r_clr_pend & ~w_take);
    end
  end

  // Next-state, gap count and pulse decode for the arbiter.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_s_nxt     = 1'b0;
    w_r_nxt     = 1'b0;
    w_conf_nxt  = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_set_pend || r_clr_pend) begin
          w_state_nxt = ISSUE;
          w_take      = 1'b1;
          if (r_set_pend && r_clr_pend) begin
            w_conf_nxt = 1'b1;
            w_s_nxt    = SET_PRIORITY;
            w_r_nxt    = ~SET_PRIORITY;
          end else begin
            w_s_nxt = r_set_pend;
            w_r_nxt = r_clr_pend;
          end
        end
      end
      ISSUE: begin
        if (GAP_CYCLES > 0) begin
          w_state_nxt = GAP;
          w_gap_nxt   = GAP_LOAD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = IDLE;
        else                 w_gap_nxt   = r_gap_cnt - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, gap counter and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gap_cnt  <= '0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_s        <= w_s_nxt;
      r_r        <= w_r_nxt;
      r_conflict <= w_conf_nxt;
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign conflict = r_conflict;
  assign busy     = (r_state != IDLE);

`ifdef SR_CONFLICT_CNT_EN
  logic [7:0] r_conflict_cnt;

  // Saturating count of conflicts, updated alongside the conflict pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_conflict_cnt <= '0;
    else if (w_conf_nxt && r_conflict_cnt != 8'hFF) r_conflict_cnt <= r_conflict_cnt + 8'd1;
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule : sr_cmd_conditioner
